// File: rtl/sc_input_cond.sv
// Input conditioning for push-buttons and slide switches: two-flop synchronizers, per-bit debounce,
// key press pulses and sticky press flags. Define INPUT_COND_SW_DEBOUNCE_EN to debounce switches.
module sc_input_cond #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] key_raw,
  input  logic [9:0] sw_raw,
  input  logic       flag_clr,
  input  logic [3:0] flag_clr_mask,
  output logic [3:0] key_out,
  output logic [9:0] sw_out,
  output logic [3:0] key_pulse,
  output logic [3:0] key_flag
);

  localparam int unsigned NumKeys = 4;
  localparam int unsigned NumSw   = 10;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchronizers; keys reset to the released (high) pin level so release never looks like a press.
  logic [NumKeys-1:0] r_key_meta;
  logic [NumKeys-1:0] r_key_sync;
  logic [NumSw-1:0]   r_sw_meta;
  logic [NumSw-1:0]   r_sw_sync;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_meta <= '1;
      r_key_sync <= '1;
      r_sw_meta  <= '0;
      r_sw_sync  <= '0;
    end else begin
      r_key_meta <= key_raw;
      r_key_sync <= r_key_meta;
      r_sw_meta  <= sw_raw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  logic [NumKeys-1:0] w_key_lvl;
  assign w_key_lvl = ~r_key_sync;

  // Key debounce
  logic [NumKeys-1:0] r_key_stable;
  logic [NumKeys-1:0] w_key_stable_d;
  logic [CNT_W-1:0]   r_key_cnt [NumKeys];
  logic [CNT_W-1:0]   w_key_cnt_d [NumKeys];
  logic [NumKeys-1:0] w_key_rise;

  always_comb begin
    w_key_stable_d = r_key_stable;
    w_key_rise     = '0;
    for (int i = 0; i < int'(NumKeys); i++) begin
      w_key_cnt_d[i] = '0;
      if (w_key_lvl[i] != r_key_stable[i]) begin
        if (r_key_cnt[i] == CntLast) begin
          w_key_stable_d[i] = w_key_lvl[i];
          w_key_rise[i]     = w_key_lvl[i];
        end else begin
          w_key_cnt_d[i] = r_key_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_stable <= '0;
      for (int i = 0; i < int'(NumKeys); i++) begin
        r_key_cnt[i] <= '0;
      end
    end else begin
      r_key_stable <= w_key_stable_d;
      for (int i = 0; i < int'(NumKeys); i++) begin
        r_key_cnt[i] <= w_key_cnt_d[i];
      end
    end
  end

  // Press pulse and sticky flags; a pulse arriving with a clear of the same bit keeps the flag set.
  logic [NumKeys-1:0] r_key_pulse;
  logic [NumKeys-1:0] r_key_flag;
  logic [NumKeys-1:0] w_key_flag_d;
  logic [NumKeys-1:0] w_clr;

  always_comb begin
    w_clr        = flag_clr ? flag_clr_mask : '0;
    w_key_flag_d = (r_key_flag & ~w_clr) | r_key_pulse;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_key_pulse <= '0;
      r_key_flag  <= '0;
    end else begin
      r_key_pulse <= w_key_rise;
      r_key_flag  <= w_key_flag_d;
    end
  end

  assign key_out   = r_key_stable;
  assign key_pulse = r_key_pulse;
  assign key_flag  = r_key_flag;

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  // Switch debounce, same rule as the keys
  logic [NumSw-1:0] r_sw_stable;
  logic [NumSw-1:0] w_sw_stable_d;
  logic [CNT_W-1:0] r_sw_cnt [NumSw];
  logic [CNT_W-1:0] w_sw_cnt_d [NumSw];

  always_comb begin
    w_sw_stable_d = r_sw_stable;
    for (int i = 0; i < int'(NumSw); i++) begin
      w_sw_cnt_d[i] = '0;
      if (r_sw_sync[i] != r_sw_stable[i]) begin
        if (r_sw_cnt[i] == CntLast) begin
          w_sw_stable_d[i] = r_sw_sync[i];
        end else begin
          w_sw_cnt_d[i] = r_sw_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sw_stable <= '0;
      for (int i = 0; i < int'(NumSw); i++) begin
        r_sw_cnt[i] <= '0;
      end
    end else begin
      r_sw_stable <= w_sw_stable_d;
      for (int i = 0; i < int'(NumSw); i++) begin
        r_sw_cnt[i] <= w_sw_cnt_d[i];
      end
    end
  end

  assign sw_out = r_sw_stable;
`else
  assign sw_out = r_sw_sync;
`endif

endmodule
